pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised program counter for the IF stage. Next generation of the single-PC block.
- Arbitrates N prioritised redirect channels (e.g. JR, branch) against sequential fetch, with stall.
- Keeps a depth-configurable checkpoint stack of fall-through addresses, so mispredicted redirects can be undone over several levels.
- Drives the instruction RAM address and the IF_ID PC-plus-step value, and pulses FLUSH on every redirect or restore.

Parameters:
ADDR_W, 32, PC/address width in bits
STEP, 1, sequential increment (1 = word-addressed RAM, 4 = byte-addressed)
RESET_VECTOR, 0, PC value loaded on reset
NUM_REDIRECT, 2, number of redirect channels; index 0 has highest priority
HIST_DEPTH, 4, checkpoint stack entries (>=1)

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  synchronous, active-high reset
PC_WRITE  in  1  0 = stall: hold all state, ignore redirect/restore
REDIRECT_VALID  in  NUM_REDIRECT  per-channel redirect request
REDIRECT_ADDR  in  NUM_REDIRECT*ADDR_W  channel i target at bits [i*ADDR_W +: ADDR_W]
RESTORE  in  1  pop the newest checkpoint and resume fetch from it
FETCH_ADDRESS  out  ADDR_W  current PC (registered), to instruction RAM
PC_PLUS_STEP  out  ADDR_W  FETCH_ADDRESS+STEP mod 2^ADDR_W, to IF_ID
FLUSH  out  1  registered one-cycle pulse: FETCH_ADDRESS this cycle came from a redirect or restore
RESTORE_ERR  out  1  registered one-cycle pulse: RESTORE seen with empty stack
HIST_COUNT  out  clog2(HIST_DEPTH+1)  valid checkpoint entries

Behaviour:
- Reset: one clock, synchronous, active-high. Applied at an edge with RESET=1, it sets pc=RESET_VECTOR, FLUSH=0, RESTORE_ERR=0, HIST_COUNT=0 (stack contents don't-care).
  - RESET overrides PC_WRITE, RESTORE and redirects.
  - Mid-operation reset discards all checkpoints.
- Latency: a request sampled at edge t appears on FETCH_ADDRESS after edge t. No combinational path from inputs to FETCH_ADDRESS.
- PC_PLUS_STEP is combinational from the pc register only. Wraps modulo 2^ADDR_W.
- Next-pc priority, evaluated only when PC_WRITE=1:
  1. RESTORE with HIST_COUNT>0: pc <= newest entry; pop; FLUSH<=1; all redirects dropped.
  2. RESTORE with HIST_COUNT=0: RESTORE_ERR<=1; the request falls through to rule 3/4 as if RESTORE were low.
  3. Any REDIRECT_VALID: the lowest set index i wins. pc <= REDIRECT_ADDR[i]; push pc+STEP (the replaced fall-through); FLUSH<=1.
  4. Otherwise: pc <= pc+STEP; FLUSH<=0.
- PC_WRITE=0: pc, stack and HIST_COUNT hold. FLUSH<=0, RESTORE_ERR<=0. Requests are not queued; the requester must hold them until the stall clears.
- Checkpoint stack: circular LIFO.
  - Push when full overwrites the oldest entry; HIST_COUNT saturates at HIST_DEPTH.
  - Push and pop never occur in the same cycle (rule 1 excludes rule 3).
  - The write pointer wraps modulo HIST_DEPTH; HIST_DEPTH need not be a power of two.
- A redirect target equal to the current pc is legal and still pushes and flushes.

Decomposition:
- Package pc_pkg holds:
  - channel index constants CH_JR=0, CH_BRANCH=1
  - default RESET_VECTOR
  - a clog2 width function for HIST_COUNT and the pointers
- Sub-module pc_hist_stack (parameters ADDR_W, HIST_DEPTH).
  - Ports: CLOCK, RESET, push, push_data, pop, top_data, count.
  - Top-of-stack read is combinational; overwrite-oldest is implemented internally.
- The top level holds the priority encoder, the pc register and the pulse flops.

Test Plan:
- Reset/sequential: defaults, RESET=1 for 2 cycles, then PC_WRITE=1 → FETCH_ADDRESS 0,1,2,3; PC_PLUS_STEP 1,2,3,4; FLUSH=0; HIST_COUNT=0.
- Priority: at pc=5, assert ch0=0x40 and ch1=0x80 together → next FETCH_ADDRESS=0x40, FLUSH=1 for one cycle, HIST_COUNT=1; then 0x41.
- Restore: continuing, after 2 sequential cycles assert RESTORE → FETCH_ADDRESS=6, FLUSH=1, HIST_COUNT=0. Assert RESTORE again → RESTORE_ERR=1, FETCH_ADDRESS=7.
- Stall: PC_WRITE=0 for 3 cycles with ch1 valid (0x80) and RESTORE=1 → FETCH_ADDRESS, HIST_COUNT unchanged; FLUSH=0, RESTORE_ERR=0.
- Overflow: HIST_DEPTH=4; five redirects from pcs 0x10,0x20,0x30,0x40,0x50 (each target = next pc) → HIST_COUNT=4. Four restores yield 0x51,0x41,0x31,0x21; a fifth gives RESTORE_ERR=1.
- Wrap/reset: with RESET_VECTOR=0xFFFFFFFF, PC_PLUS_STEP=0 and the next fetch is 0. With HIST_COUNT=3, assert RESET together with RESTORE → pc=0xFFFFFFFF, HIST_COUNT=0, FLUSH=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and helpers for the IF-stage program counter.
//   CH_JR / CH_BRANCH    redirect channel indices (lower index = higher priority)
//   DEFAULT_RESET_VECTOR default PC after reset
//   clog2w()             bit width needed to index/count n things (never below 1)
package pc_pkg;

   localparam int unsigned CH_JR     = 0;
   localparam int unsigned CH_BRANCH = 1;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   // Width of a field holding values 0..n-1; clamps to 1 so depth-1 stacks still get a bit.
   function automatic int unsigned clog2w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pc_hist_stack.sv
// pc_hist_stack: circular LIFO of fall-through addresses for redirect undo.
//   CLOCK      rising-edge clock
//   RESET      synchronous active-high reset; empties the stack
//   push       write push_data as the newest entry (overwrites oldest when full)
//   push_data  address to checkpoint
//   pop        discard the newest entry (caller guarantees count > 0)
//   top_data   newest entry, combinational
//   count      number of valid entries, saturates at HIST_DEPTH
module pc_hist_stack
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned HIST_DEPTH = 4
) (
   input  logic                                 CLOCK,
   input  logic                                 RESET,
   input  logic                                 push,
   input  logic [ADDR_W-1:0]                    push_data,
   input  logic                                 pop,
   output logic [ADDR_W-1:0]                    top_data,
   output logic [clog2w(HIST_DEPTH+1)-1:0]      count
);

   localparam int unsigned PtrW = clog2w(HIST_DEPTH);
   localparam int unsigned CntW = clog2w(HIST_DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(HIST_DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(HIST_DEPTH);

   logic [ADDR_W-1:0] mem_q [HIST_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr;
   logic [CntW-1:0]   count_q, count_d;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
      return (p == '0) ? LastPtr : p - PtrW'(1);
   endfunction

   // wr_ptr names the next free slot; the newest entry sits just below it.
   assign rd_ptr   = ptr_dec(wr_ptr_q);
   assign top_data = mem_q[rd_ptr];
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
         if (count_q != FullCnt) begin
            count_d = count_q + CntW'(1);
         end
      end else if (pop) begin
         wr_ptr_d = ptr_dec(wr_ptr_q);
         count_d  = count_q - CntW'(1);
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: count gates which slots are meaningful.
   always_ff @(posedge CLOCK) begin
      if (!RESET && push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter with prioritised redirects, stall and
// multi-level checkpoint restore.
//   CLOCK           rising-edge clock
//   RESET           synchronous active-high reset (overrides everything)
//   PC_WRITE        0 = stall: hold state, ignore redirect/restore
//   REDIRECT_VALID  per-channel redirect request, index 0 highest priority
//   REDIRECT_ADDR   channel i target at [i*ADDR_W +: ADDR_W]
//   RESTORE         pop newest checkpoint and resume fetch from it
//   FETCH_ADDRESS   registered PC to instruction RAM
//   PC_PLUS_STEP    FETCH_ADDRESS + STEP (wrapping), to IF_ID
//   FLUSH           one-cycle pulse: FETCH_ADDRESS came from redirect/restore
//   RESTORE_ERR     one-cycle pulse: RESTORE with empty stack
//   HIST_COUNT      valid checkpoint entries
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter int unsigned       STEP         = 1,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
   parameter int unsigned       NUM_REDIRECT = 2,
   parameter int unsigned       HIST_DEPTH   = 4
) (
   input  logic                               CLOCK,
   input  logic                               RESET,
   input  logic                               PC_WRITE,
   input  logic [NUM_REDIRECT-1:0]            REDIRECT_VALID,
   input  logic [NUM_REDIRECT*ADDR_W-1:0]     REDIRECT_ADDR,
   input  logic                               RESTORE,
   output logic [ADDR_W-1:0]                  FETCH_ADDRESS,
   output logic [ADDR_W-1:0]                  PC_PLUS_STEP,
   output logic                               FLUSH,
   output logic                               RESTORE_ERR,
   output logic [clog2w(HIST_DEPTH+1)-1:0]    HIST_COUNT
);

   localparam int unsigned CntW = clog2w(HIST_DEPTH + 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_plus;
   logic              flush_q, flush_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] redir_addr;
   logic              redir_any;
   logic              push, pop;
   logic [ADDR_W-1:0] top_data;
   logic [CntW-1:0]   hist_count;

   assign pc_plus = pc_q + ADDR_W'(STEP);

   // Walk from highest index down so the lowest set channel is assigned last and wins.
   always_comb begin
      redir_addr = '0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         if (REDIRECT_VALID[i]) begin
            redir_addr = REDIRECT_ADDR[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign redir_any = |REDIRECT_VALID;

   always_comb begin
      pc_d    = pc_q;
      flush_d = 1'b0;
      err_d   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      if (PC_WRITE) begin
         if (RESTORE && (hist_count != '0)) begin
            pc_d    = top_data;
            pop     = 1'b1;
            flush_d = 1'b1;
         end else begin
            // An empty-stack restore only flags an error; fetch carries on normally.
            err_d = RESTORE;
            if (redir_any) begin
               pc_d    = redir_addr;
               push    = 1'b1;
               flush_d = 1'b1;
            end else begin
               pc_d = pc_plus;
            end
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pc_q    <= RESET_VECTOR;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   pc_hist_stack #(
      .ADDR_W     (ADDR_W),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .push      (push),
      .push_data (pc_plus),
      .pop       (pop),
      .top_data  (top_data),
      .count     (hist_count)
   );

   assign FETCH_ADDRESS = pc_q;
   assign PC_PLUS_STEP  = pc_plus;
   assign FLUSH         = flush_q;
   assign RESTORE_ERR   = err_q;
   assign HIST_COUNT    = hist_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
   import pc_pkg::*;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        PC_WRITE;
   logic [1:0]  REDIRECT_VALID;
   logic [63:0] REDIRECT_ADDR;
   logic        RESTORE;

   logic [31:0] fa, pcp, fa_w, pcp_w;
   logic        flush, err, flush_w, err_w;
   logic [2:0]  hc, hc_w;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLOCK = ~CLOCK;

   pc_fetch_unit dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .PC_WRITE       (PC_WRITE),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_ADDR  (REDIRECT_ADDR),
      .RESTORE        (RESTORE),
      .FETCH_ADDRESS  (fa),
      .PC_PLUS_STEP   (pcp),
      .FLUSH          (flush),
      .RESTORE_ERR    (err),
      .HIST_COUNT     (hc)
   );

   pc_fetch_unit #(
      .RESET_VECTOR (32'hFFFF_FFFF)
   ) dut_w (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .PC_WRITE       (PC_WRITE),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_ADDR  (REDIRECT_ADDR),
      .RESTORE        (RESTORE),
      .FETCH_ADDRESS  (fa_w),
      .PC_PLUS_STEP   (pcp_w),
      .FLUSH          (flush_w),
      .RESTORE_ERR    (err_w),
      .HIST_COUNT     (hc_w)
   );

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [31:0] a);
      REDIRECT_ADDR[ch*32 +: 32] = a;
   endtask

   initial begin
      RESET = 1'b1; PC_WRITE = 1'b0; REDIRECT_VALID = '0; REDIRECT_ADDR = '0; RESTORE = 1'b0;

      // Reset and sequential fetch
      tick(); tick();
      chk("rst_pc", fa, 32'h0);
      chk("rst_pcp", pcp, 32'h1);
      chk("rst_flush", {31'b0, flush}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_hc", {29'b0, hc}, 32'h0);
      RESET = 1'b0; PC_WRITE = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("seq_pc", fa, 32'(i));
         chk("seq_pcp", pcp, 32'(i + 1));
         chk("seq_flush", {31'b0, flush}, 32'h0);
         chk("seq_hc", {29'b0, hc}, 32'h0);
      end

      // Priority: both channels at pc=5, channel 0 wins
      set_ch(CH_JR, 32'h40); set_ch(CH_BRANCH, 32'h80); REDIRECT_VALID = 2'b11;
      tick();
      chk("prio_pc", fa, 32'h40);
      chk("prio_flush", {31'b0, flush}, 32'h1);
      chk("prio_hc", {29'b0, hc}, 32'h1);
      REDIRECT_VALID = 2'b00;
      tick();
      chk("post_pc", fa, 32'h41);
      chk("post_flush", {31'b0, flush}, 32'h0);
      tick();
      chk("post2_pc", fa, 32'h42);

      // Restore to fall-through, then restore on empty stack
      RESTORE = 1'b1;
      tick();
      chk("rest_pc", fa, 32'h6);
      chk("rest_flush", {31'b0, flush}, 32'h1);
      chk("rest_hc", {29'b0, hc}, 32'h0);
      tick();
      chk("rerr_err", {31'b0, err}, 32'h1);
      chk("rerr_pc", fa, 32'h7);
      chk("rerr_flush", {31'b0, flush}, 32'h0);
      RESTORE = 1'b0;

      // Redirect via channel 1 then stall with requests pending
      REDIRECT_VALID = 2'b10;
      tick();
      chk("ch1_pc", fa, 32'h80);
      chk("ch1_err_clr", {31'b0, err}, 32'h0);
      chk("ch1_hc", {29'b0, hc}, 32'h1);
      PC_WRITE = 1'b0; RESTORE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", fa, 32'h80);
         chk("stall_hc", {29'b0, hc}, 32'h1);
         chk("stall_flush", {31'b0, flush}, 32'h0);
         chk("stall_err", {31'b0, err}, 32'h0);
      end
      PC_WRITE = 1'b1; RESTORE = 1'b0; REDIRECT_VALID = 2'b00;
      tick();
      chk("unstall_pc", fa, 32'h81);

      // Overflow: pushes 0x1,0x11,0x21,0x31,0x41,0x51 into a 4-deep stack
      RESET = 1'b1; tick(); RESET = 1'b0;
      chk("ovf_rst_hc", {29'b0, hc}, 32'h0);
      REDIRECT_VALID = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         set_ch(CH_JR, 32'(k * 16));
         tick();
         chk("ovf_pc", fa, 32'(k * 16));
         chk("ovf_hc", {29'b0, hc}, (k < 4) ? 32'(k) : 32'd4);
      end
      REDIRECT_VALID = 2'b00; RESTORE = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pop_pc", fa, 32'h51 - 32'(k * 16));
         chk("pop_flush", {31'b0, flush}, 32'h1);
         chk("pop_hc", {29'b0, hc}, 32'(3 - k));
      end
      tick();
      chk("pop5_err", {31'b0, err}, 32'h1);
      chk("pop5_pc", fa, 32'h22);
      RESTORE = 1'b0;

      // Redirect to the current pc still pushes and flushes
      set_ch(CH_BRANCH, 32'h22); REDIRECT_VALID = 2'b10;
      tick();
      chk("self_pc", fa, 32'h22);
      chk("self_flush", {31'b0, flush}, 32'h1);
      chk("self_hc", {29'b0, hc}, 32'h1);
      REDIRECT_VALID = 2'b00;

      // Wrap and reset-over-restore on the 0xFFFFFFFF instance
      RESET = 1'b1; tick(); RESET = 1'b0;
      chk("wrap_pc", fa_w, 32'hFFFF_FFFF);
      chk("wrap_pcp", pcp_w, 32'h0);
      tick();
      chk("wrap_next", fa_w, 32'h0);
      set_ch(CH_JR, 32'h100); REDIRECT_VALID = 2'b01;
      tick(); tick(); tick();
      chk("wrap_hc3", {29'b0, hc_w}, 32'h3);
      REDIRECT_VALID = 2'b00; RESET = 1'b1; RESTORE = 1'b1;
      tick();
      chk("rr_pc", fa_w, 32'hFFFF_FFFF);
      chk("rr_hc", {29'b0, hc_w}, 32'h0);
      chk("rr_flush", {31'b0, flush_w}, 32'h0);
      chk("rr_err", {31'b0, err_w}, 32'h0);
      chk("rr_main_pc", fa, 32'h0);
      RESET = 1'b0; RESTORE = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
